riscv_rvfimon_ctrl: RTL and testbench

Run controller for the RVFI monitor in the testbench. It masks monitor error codes until reset has been applied and released and has settled. It then watches retirement for hangs, latches the first failure, drains for a fixed window, and raises a halt request to end the simulation cleanly. It sits between the core's RVFI retirement strobe, the monitor's `errcode` output and the top-level test-end logic.

---
 rtl/riscv_rvfimon_pkg.sv | 18 +
 rtl/riscv_sat_counter.sv | 22 ++
 rtl/riscv_rvfimon_ctrl.sv | 149 ++++++++++++++
 tb/tb_riscv_rvfimon_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_rvfimon_pkg.sv
// Shared types and constants for the RVFI monitor run controller.
package riscv_rvfimon_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    ARMED  = 2'd1,
    DRAIN  = 2'd2,
    HALT   = 2'd3
  } rvfimon_state_e;

  typedef enum logic {
    MON  = 1'b0,
    WDOG = 1'b1
  } rvfimon_src_e;

  localparam logic [15:0] WDOG_ERRCODE = 16'hFFFF;

endpackage

// File: rtl/riscv_sat_counter.sv
// Up-counter with synchronous clear that sticks at its maximum value.
module riscv_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/riscv_rvfimon_ctrl.sv
// RVFI monitor run controller: masks errors while settling, captures the first
// monitor or watchdog failure, drains for a fixed window and then requests halt.
module riscv_rvfimon_ctrl
  import riscv_rvfimon_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned DRAIN_CYCLES  = 8,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rvfi_valid,
  input  logic [15:0]      errcode,
  input  logic             clear,
  output rvfimon_state_e   state_o,
  output logic             err_valid,
  output logic             err_src,
  output logic [15:0]      err_code,
  output logic [CNT_W-1:0] err_cycle,
  output logic [CNT_W-1:0] err_retire,
  output logic [CNT_W-1:0] retire_count,
  output logic [7:0]       late_errs,
  output logic             halt_req
);

  localparam logic [7:0]       SettleInit = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      DrainInit  = 32'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] IdleLast   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  rvfimon_state_e   state_q, state_d;
  logic [7:0]       settle_q, settle_d;
  logic [31:0]      drain_q, drain_d;
  logic [CNT_W-1:0] cycle_count, idle_count, retire_next;
  logic             armed, arm_now, rearm, mon_hit, wdog_hit, capture, late_hit;

  assign armed    = (state_q == ARMED);
  assign arm_now  = (state_q == SETTLE) && (settle_q == 8'd0);
  assign rearm    = (state_q == HALT) && clear;
  assign mon_hit  = armed && (errcode != 16'd0);
  assign wdog_hit = armed && (TIMEOUT != 0) && (idle_count == IdleLast) && !rvfi_valid;
  assign capture  = mon_hit || wdog_hit;
  assign late_hit = ((state_q == DRAIN) || (state_q == HALT)) && (errcode != 16'd0);

  // Retire count as it will read after this edge, so the capture includes it.
  assign retire_next = (rvfi_valid && (retire_count != {CNT_W{1'b1}})) ?
                       retire_count + CNT_W'(1) : retire_count;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    drain_d  = drain_q;
    case (state_q)
      SETTLE: begin
        if (settle_q == 8'd0) state_d = ARMED;
        else                  settle_d = settle_q - 8'd1;
      end
      ARMED: begin
        if (capture) begin
          state_d = DRAIN;
          drain_d = DrainInit;
        end
      end
      DRAIN: begin
        if (drain_q == 32'd0) state_d = HALT;
        else                  drain_d = drain_q - 32'd1;
      end
      HALT: begin
        if (clear) begin
          state_d  = SETTLE;
          settle_d = SettleInit;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= SETTLE;
      settle_q <= SettleInit;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      drain_q  <= drain_d;
    end
  end

  // Capture can only happen in ARMED, which is left on the same edge, so the
  // first failure is never overwritten.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_valid  <= 1'b0;
      err_src    <= 1'b0;
      err_code   <= '0;
      err_cycle  <= '0;
      err_retire <= '0;
    end else if (rearm) begin
      err_valid  <= 1'b0;
      err_src    <= 1'b0;
      err_code   <= '0;
      err_cycle  <= '0;
      err_retire <= '0;
    end else if (capture) begin
      err_valid  <= 1'b1;
      err_src    <= mon_hit ? MON : WDOG;
      err_code   <= mon_hit ? errcode : WDOG_ERRCODE;
      err_cycle  <= cycle_count;
      err_retire <= retire_next;
    end
  end

  riscv_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .clear (arm_now),
    .inc   (armed),
    .count (cycle_count)
  );

  riscv_sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clock (clock),
    .reset (reset),
    .clear (arm_now),
    .inc   (armed && rvfi_valid),
    .count (retire_count)
  );

  riscv_sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clock (clock),
    .reset (reset),
    .clear (arm_now || (armed && rvfi_valid)),
    .inc   (armed && !rvfi_valid),
    .count (idle_count)
  );

  riscv_sat_counter #(.W(8)) u_late_cnt (
    .clock (clock),
    .reset (reset),
    .clear (rearm),
    .inc   (late_hit),
    .count (late_errs)
  );

  assign state_o  = state_q;
  assign halt_req = (state_q == HALT);

endmodule

// File: tb/tb_riscv_rvfimon_ctrl.sv
// Directed bench for the RVFI monitor run controller with hand-computed expectations.
module tb_riscv_rvfimon_ctrl;
  import riscv_rvfimon_pkg::*;

  logic           clock;
  logic           reset;
  logic           rvfi_valid;
  logic [15:0]    errcode;
  logic           clear;
  rvfimon_state_e state_o;
  logic           err_valid;
  logic           err_src;
  logic [15:0]    err_code;
  logic [31:0]    err_cycle;
  logic [31:0]    err_retire;
  logic [31:0]    retire_count;
  logic [7:0]     late_errs;
  logic           halt_req;

  int checks = 0;
  int errors = 0;

  riscv_rvfimon_ctrl #(
    .SETTLE_CYCLES (2),
    .TIMEOUT       (16),
    .DRAIN_CYCLES  (8),
    .CNT_W         (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rvfi_valid   (rvfi_valid),
    .errcode      (errcode),
    .clear        (clear),
    .state_o      (state_o),
    .err_valid    (err_valid),
    .err_src      (err_src),
    .err_code     (err_code),
    .err_cycle    (err_cycle),
    .err_retire   (err_retire),
    .retire_count (retire_count),
    .late_errs    (late_errs),
    .halt_req     (halt_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    rvfi_valid = 1'b0;
    errcode    = 16'd0;
    clear      = 1'b0;
    tick(2);
    check("rst_state", state_o, SETTLE);
    check("rst_halt", halt_req, 0);
    check("rst_valid", err_valid, 0);
    check("rst_code", err_code, 0);
    check("rst_retire_cnt", retire_count, 0);
    check("rst_late", late_errs, 0);

    // Settle masking
    reset   = 1'b0;
    errcode = 16'h0005;
    tick(1);
    check("settle_state1", state_o, SETTLE);
    check("settle_masked", err_valid, 0);
    errcode = 16'h0000;
    tick(1);
    check("settle_armed", state_o, ARMED);
    check("settle_nocap", err_valid, 0);

    // Monitor error after 10 retirements
    rvfi_valid = 1'b1;
    tick(10);
    check("mon_retire10", retire_count, 10);
    errcode = 16'h0003;
    tick(1);
    check("mon_state", state_o, DRAIN);
    check("mon_valid", err_valid, 1);
    check("mon_src", err_src, 0);
    check("mon_code", err_code, 3);
    check("mon_retire", err_retire, 11);
    check("mon_cycle", err_cycle, 10);
    errcode    = 16'h0000;
    rvfi_valid = 1'b0;
    clear      = 1'b1;
    tick(1);
    check("drain_clear_ign", state_o, DRAIN);
    clear = 1'b0;
    tick(7);
    check("halt_not_yet", halt_req, 0);
    tick(1);
    check("halt_rise", halt_req, 1);
    check("halt_state", state_o, HALT);
    check("halt_late0", late_errs, 0);

    // Re-arm from HALT
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_state", state_o, SETTLE);
    check("clr_valid", err_valid, 0);
    check("clr_code", err_code, 0);
    check("clr_retire", err_retire, 0);
    check("clr_cycle", err_cycle, 0);
    tick(2);
    check("rearm_state", state_o, ARMED);

    // Watchdog: pulse at idle cycle 15 holds it off
    tick(14);
    rvfi_valid = 1'b1;
    tick(1);
    rvfi_valid = 1'b0;
    tick(1);
    check("wd_pulse_saves", state_o, ARMED);
    tick(14);
    check("wd_15idle", err_valid, 0);
    tick(1);
    check("wd_state", state_o, DRAIN);
    check("wd_src", err_src, 1);
    check("wd_code", err_code, 16'hFFFF);
    check("wd_cycle", err_cycle, 30);
    check("wd_retire", err_retire, 1);
    tick(9);
    check("wd_halt", halt_req, 1);

    // Simultaneous watchdog expiry and monitor error
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(2);
    check("sim_armed", state_o, ARMED);
    tick(15);
    errcode = 16'h0002;
    tick(1);
    check("sim_src", err_src, 0);
    check("sim_code", err_code, 2);
    check("sim_cycle", err_cycle, 15);

    // Late errors saturate, capture stays
    errcode = 16'h0007;
    tick(300);
    check("late_sat", late_errs, 255);
    check("late_code_kept", err_code, 2);
    check("late_src_kept", err_src, 0);
    check("late_halt", halt_req, 1);

    // Asynchronous reset while halted
    reset = 1'b1;
    #2;
    check("arst_halt", halt_req, 0);
    check("arst_late", late_errs, 0);
    check("arst_state", state_o, SETTLE);
    errcode = 16'h0000;
    tick(1);
    reset = 1'b0;
    tick(2);
    check("rst2_armed", state_o, ARMED);

    // Asynchronous reset mid-DRAIN
    errcode = 16'h0001;
    tick(1);
    check("d_cap", err_valid, 1);
    errcode = 16'h0000;
    tick(3);
    check("d_state", state_o, DRAIN);
    reset = 1'b1;
    #2;
    check("d_arst_valid", err_valid, 0);
    check("d_arst_halt", halt_req, 0);
    check("d_arst_state", state_o, SETTLE);
    check("d_arst_code", err_code, 0);
    tick(1);
    reset = 1'b0;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
